vga_plot_arbiter: RTL and testbench
===================================

// Module: vga_plot_arbiter
// PURPOSE
//   Shares the single VGA adapter plot port (x/y/colour/plot) between NUM_REQ pixel
//   engines, e.g. screen-clear fill and circle drawer. Each requester sends bursts of
//   pixels over a valid/ready handshake. Bursts are arbitrated round-robin, and each
//   burst owns the port until it ends. Sits between the drawing FSMs and the vga_adapter.
// PARAMETERS
//   NUM_REQ   2    number of requesters (2..8)
//   X_MAX     159  largest legal x coordinate
//   Y_MAX     119  largest legal y coordinate
//   TIMEOUT   64   idle-owner cycles before forced release (used only with ARB_TIMEOUT_EN)
// PORTS
//   clk         in   1          system clock (CLOCK_50 domain)
//   rst         in   1          asynchronous reset, active-high
//   req_valid   in   NUM_REQ    requester i presents a pixel
//   req_last    in   NUM_REQ    pixel is the final beat of requester i's burst
//   req_x       in   8*NUM_REQ  x of requester i, bits [8i+7:8i]
//   req_y       in   7*NUM_REQ  y of requester i, bits [7i+6:7i]
//   req_colour  in   3*NUM_REQ  colour of requester i, bits [3i+2:3i]
//   req_ready   out  NUM_REQ    one-hot; only the current owner may be ready
//   vga_x       out  8          registered pixel x to adapter
//   vga_y       out  7          registered pixel y to adapter
//   vga_colour  out  3          registered pixel colour to adapter
//   vga_plot    out  1          one-cycle write strobe to adapter
//   grant_id    out  3          index of current/last owner
//   busy        out  1          high while in OWN state
//   clip_cnt    out  16         count of out-of-range pixels dropped, saturating
// BEHAVIOUR
//   Reset (async): state=IDLE, rr_ptr=0, grant_id=0, req_ready=0, vga_plot=0,
//     vga_x/y/colour=0, clip_cnt=0. Applies immediately, even mid-burst. The burst is lost.
//   FSM IDLE:
//     - If any req_valid is high, select the first valid index at or after rr_ptr, wrapping
//       modulo NUM_REQ.
//     - Register that index as grant_id and go to OWN.
//     - No beat is accepted in the arbitration cycle. req_ready stays all-zero in IDLE.
//   FSM OWN:
//     - req_ready[grant_id]=1; all other ready bits are 0. Ready is combinational from
//       state and grant_id, independent of valid.
//     - A beat is accepted when req_valid[grant_id] and req_ready[grant_id] are both high.
//     - Accepted beat with last=1: go to IDLE and set rr_ptr=(grant_id+1)%NUM_REQ.
//       Other requesters are arbitrated in the following IDLE cycle. A burst boundary
//       therefore costs 1 bubble.
//   Datapath, 1-cycle latency:
//     - Accepted in-range beat (x<=X_MAX and y<=Y_MAX): on the next edge, vga_x/y/colour
//       load the beat and vga_plot=1 for exactly one cycle.
//     - Otherwise vga_plot=0, and vga_x/y/colour hold their last value.
//     - Out-of-range accepted beat: it is consumed (handshake completes), no plot, and
//       clip_cnt+1, saturating at 16'hFFFF.
//     - Back-to-back beats from the owner give one plot per cycle.
//   Wrap: rr_ptr wraps NUM_REQ-1 -> 0. grant_id never reaches NUM_REQ or above.
//   A non-owner holding valid is ignored until the owner's last beat.
//   A single-beat burst (valid+last in one beat) is legal: IDLE, OWN, IDLE.
//   The owner dropping valid mid-burst keeps ownership (no plots) until last arrives.
// CONFIGURATION
//   ARB_TIMEOUT_EN defined:
//     - In OWN, a TIMEOUT-cycle counter resets on every accepted beat and increments
//       while req_valid[grant_id]=0.
//     - When it reaches TIMEOUT, force IDLE and advance rr_ptr as for last.
//     - The counter clears on reset and on entering OWN.
//   ARB_TIMEOUT_EN undefined: no counter. Ownership ends only on an accepted last beat.
// TESTING
//   1. Reset: assert rst for 5 cycles with req_valid=2'b11. Required: req_ready=0,
//      vga_plot=0, clip_cnt=0 throughout. Release: 1 idle cycle, then req_ready=2'b01
//      (rr_ptr=0).
//   2. Req0 bursts 4 pixels (10,20,c=3)..(13,20,c=3) with last on the 4th, while req1
//      holds valid. Required: 4 consecutive vga_plot pulses, each 1 cycle after accept;
//      req_ready[1]=0 during the burst; req1 granted 1 bubble cycle after req0's last;
//      grant_id=1.
//   3. Fairness: both requesters send continuous single-beat bursts for 20 beats.
//      Required: grants alternate 0,1,0,1... and 10 plots per requester.
//   4. Clipping: owner sends (160,5), (5,120), (159,119) with last on the 3rd.
//      Required: one plot at (159,119); clip_cnt=2; all 3 beats accepted.
//   5. Reset mid-burst: after 2 of 5 beats, pulse rst between edges. Required: vga_plot=0
//      and req_ready=0 immediately, before the next edge. State IDLE, rr_ptr=0 afterwards.
//   6. ARB_TIMEOUT_EN with TIMEOUT=8: owner sends 1 non-last beat, then drops valid.
//      Required: release after 8 cycles and other requester granted. Without the macro:
//      no release after 100 cycles.

Source files
------------

// File: rtl/vga_plot_arbiter.sv
// Round-robin burst arbiter onto the single VGA plot port; 1-cycle registered pixel path.
// Optional idle-owner forced release under ARB_TIMEOUT_EN.
module vga_plot_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int X_MAX   = 159,
   parameter int Y_MAX   = 119,
   parameter int TIMEOUT = 64
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [NUM_REQ-1:0]   i_req_valid,
   input  logic [NUM_REQ-1:0]   i_req_last,
   input  logic [8*NUM_REQ-1:0] i_req_x,
   input  logic [7*NUM_REQ-1:0] i_req_y,
   input  logic [3*NUM_REQ-1:0] i_req_colour,
   output logic [NUM_REQ-1:0]   o_req_ready,
   output logic [7:0]           o_vga_x,
   output logic [6:0]           o_vga_y,
   output logic [2:0]           o_vga_colour,
   output logic                 o_vga_plot,
   output logic [2:0]           o_grant_id,
   output logic                 o_busy,
   output logic [15:0]          o_clip_cnt
);

   typedef enum logic {S_IDLE, S_OWN} state_t;

   state_t       r_state;
   logic [2:0]   r_rr_ptr;
   logic [2:0]   r_grant;
   logic [7:0]   r_x;
   logic [6:0]   r_y;
   logic [2:0]   r_colour;
   logic         r_plot;
   logic [15:0]  r_clip;
`ifdef ARB_TIMEOUT_EN
   logic [15:0]  r_idle_cnt;
`endif

   logic [NUM_REQ-1:0] w_rot;
   logic [NUM_REQ-1:0] w_ready;
   logic [3:0]         w_sum;
   logic [2:0]         w_sel;
   logic [2:0]         w_next;
   logic [7:0]         w_x;
   logic [6:0]         w_y;
   logic [2:0]         w_colour;
   logic               w_own_valid;
   logic               w_own_last;
   logic               w_in_range;

   // Rotate valids so bit 0 is rr_ptr; the lowest set bit wins.
   always_comb begin
      w_rot = NUM_REQ'({i_req_valid, i_req_valid} >> r_rr_ptr);
      w_sum = '0;
      w_sel = r_rr_ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_sum = {1'b0, r_rr_ptr} + 4'(k);
            if (w_sum >= 4'(NUM_REQ)) begin
               w_sum = w_sum - 4'(NUM_REQ);
            end
            w_sel = w_sum[2:0];
         end
      end
   end

   always_comb begin
      w_ready  = (r_state == S_OWN) ? (NUM_REQ'(1) << r_grant) : '0;
      w_x      = '0;
      w_y      = '0;
      w_colour = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_ready[i]) begin
            w_x      = i_req_x[8*i +: 8];
            w_y      = i_req_y[7*i +: 7];
            w_colour = i_req_colour[3*i +: 3];
         end
      end
      w_own_valid = |(i_req_valid & w_ready);
      w_own_last  = |(i_req_last & w_ready);
      w_in_range  = (w_x <= 8'(X_MAX)) && (w_y <= 7'(Y_MAX));
      w_next      = (r_grant == 3'(NUM_REQ - 1)) ? 3'd0 : r_grant + 3'd1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_rr_ptr   <= '0;
         r_grant    <= '0;
         r_x        <= '0;
         r_y        <= '0;
         r_colour   <= '0;
         r_plot     <= 1'b0;
         r_clip     <= '0;
`ifdef ARB_TIMEOUT_EN
         r_idle_cnt <= '0;
`endif
      end else begin
         r_plot <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (|i_req_valid) begin
                  r_grant    <= w_sel;
                  r_state    <= S_OWN;
`ifdef ARB_TIMEOUT_EN
                  r_idle_cnt <= '0;
`endif
               end
            end
            S_OWN: begin
               if (w_own_valid) begin
                  if (w_in_range) begin
                     r_x      <= w_x;
                     r_y      <= w_y;
                     r_colour <= w_colour;
                     r_plot   <= 1'b1;
                  end else if (r_clip != 16'hFFFF) begin
                     r_clip <= r_clip + 16'd1;
                  end
                  if (w_own_last) begin
                     r_state  <= S_IDLE;
                     r_rr_ptr <= w_next;
                  end
`ifdef ARB_TIMEOUT_EN
                  r_idle_cnt <= '0;
`endif
               end
`ifdef ARB_TIMEOUT_EN
               else if (r_idle_cnt == 16'(TIMEOUT - 1)) begin
                  r_state    <= S_IDLE;
                  r_rr_ptr   <= w_next;
                  r_idle_cnt <= '0;
               end else begin
                  r_idle_cnt <= r_idle_cnt + 16'd1;
               end
`endif
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_req_ready  = w_ready;
   assign o_vga_x      = r_x;
   assign o_vga_y      = r_y;
   assign o_vga_colour = r_colour;
   assign o_vga_plot   = r_plot;
   assign o_grant_id   = r_grant;
   assign o_busy       = (r_state == S_OWN);
   assign o_clip_cnt   = r_clip;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Randomised bench for vga_plot_arbiter against a transaction-level reference model.
module tb_vga_plot_arbiter;
   localparam int NR  = 2;
   localparam int TMO = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR-1:0]    valid, last;
   logic [8*NR-1:0]  rx;
   logic [7*NR-1:0]  ry;
   logic [3*NR-1:0]  rc;
   logic [NR-1:0]    ready;
   logic [7:0]       vx;
   logic [6:0]       vy;
   logic [2:0]       vc;
   logic             plot;
   logic [2:0]       grant;
   logic             busy;
   logic [15:0]      clip;

   vga_plot_arbiter #(.NUM_REQ(NR), .X_MAX(159), .Y_MAX(119), .TIMEOUT(TMO)) dut (
      .i_clk(clk), .i_rst(rst), .i_req_valid(valid), .i_req_last(last),
      .i_req_x(rx), .i_req_y(ry), .i_req_colour(rc), .o_req_ready(ready),
      .o_vga_x(vx), .o_vga_y(vy), .o_vga_colour(vc), .o_vga_plot(plot),
      .o_grant_id(grant), .o_busy(busy), .o_clip_cnt(clip));

   always #5 clk = ~clk;

   typedef struct {
      int x;
      int y;
      int c;
      bit l;
   } beat_t;

   beat_t q [NR][$];
   int    gap_pct;
   int    p_cnt [NR];
   int    compared = 0;
   int    mismatched = 0;

   // Reference model: who owns the port, who is next in line, what the screen last got.
   int m_owner, m_rr, m_grant, m_idle, m_x, m_y, m_c, m_clip, m_beats;
   bit m_plot;

   task automatic check(input string tag, input int obs, input int exp);
      compared++;
      if (obs != exp) begin
         mismatched++;
         $display("FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_rr = 0; m_grant = 0; m_idle = 0;
      m_x = 0; m_y = 0; m_c = 0; m_clip = 0; m_plot = 0;
      for (int i = 0; i < NR; i++) q[i].delete();
   endtask

   task automatic model_edge();
      beat_t b;
      int    sel;
      m_plot = 0;
      if (m_owner < 0) begin
         sel = -1;
         for (int k = 0; k < NR; k++)
            if (sel < 0 && valid[(m_rr + k) % NR]) sel = (m_rr + k) % NR;
         if (sel >= 0) begin
            m_owner = sel; m_grant = sel; m_idle = 0;
         end
      end else if (valid[m_owner]) begin
         b = q[m_owner].pop_front();
         m_beats++;
         m_idle = 0;
         if (b.x <= 159 && b.y <= 119) begin
            m_x = b.x; m_y = b.y; m_c = b.c; m_plot = 1;
         end else if (m_clip < 65535) begin
            m_clip++;
         end
         if (b.l) begin
            m_rr = (m_owner + 1) % NR;
            m_owner = -1;
         end
      end else begin
`ifdef ARB_TIMEOUT_EN
         m_idle++;
         if (m_idle == TMO) begin
            m_rr = (m_owner + 1) % NR;
            m_owner = -1;
         end
`endif
      end
   endtask

   task automatic step();
      check("ready", int'(ready), (m_owner >= 0) ? (1 << m_owner) : 0);
      check("plot", int'(plot), int'(m_plot));
      check("vga_x", int'(vx), m_x);
      check("vga_y", int'(vy), m_y);
      check("vga_colour", int'(vc), m_c);
      check("grant_id", int'(grant), m_grant);
      check("busy", int'(busy), int'(m_owner >= 0));
      check("clip_cnt", int'(clip), m_clip);
      if (plot && int'(grant) < NR) p_cnt[int'(grant)]++;
      for (int i = 0; i < NR; i++) begin
         if (q[i].size() > 0) begin
            valid[i]       = ($urandom_range(0, 99) >= gap_pct);
            last[i]        = q[i][0].l;
            rx[8*i +: 8]   = 8'(q[i][0].x);
            ry[7*i +: 7]   = 7'(q[i][0].y);
            rc[3*i +: 3]   = 3'(q[i][0].c);
         end else begin
            valid[i]       = 1'b0;
            last[i]        = 1'($urandom_range(0, 1));
            rx[8*i +: 8]   = 8'($urandom_range(0, 255));
            ry[7*i +: 7]   = 7'($urandom_range(0, 127));
            rc[3*i +: 3]   = 3'($urandom_range(0, 7));
         end
      end
      model_edge();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push(input int r, input int x, input int y, input int c, input bit l);
      beat_t b;
      b.x = x; b.y = y; b.c = c; b.l = l;
      q[r].push_back(b);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((q[0].size() > 0 || q[1].size() > 0 || m_owner >= 0 || m_plot) && n < 600) begin
         step();
         n++;
      end
      check({tag, "_drain_bound"}, int'(n >= 600), 0);
   endtask

   task automatic clear_counts();
      for (int i = 0; i < NR; i++) p_cnt[i] = 0;
   endtask

   initial begin
      rst = 1'b1; valid = '1; last = '0; rx = '0; ry = '0; rc = '0;
      gap_pct = 0;
      m_beats = 0;
      model_reset();
      clear_counts();
      repeat (5) begin
         @(negedge clk);
         check("rst_ready", int'(ready), 0);
         check("rst_plot", int'(plot), 0);
         check("rst_clip", int'(clip), 0);
      end
      rst = 1'b0;

      // Req0 burst while req1 waits; model enforces one-bubble handover and latency.
      for (int i = 0; i < 4; i++) push(0, 10 + i, 20, 3, i == 3);
      for (int i = 0; i < 3; i++) push(1, 50 + i, 60, 5, i == 2);
      drain("burst");
      check("burst_plots_r0", p_cnt[0], 4);
      check("burst_plots_r1", p_cnt[1], 3);
      check("burst_grant_end", int'(grant), 1);

      // Fairness with continuous single-beat bursts.
      clear_counts();
      for (int i = 0; i < 10; i++) begin
         push(0, i, i, 1, 1'b1);
         push(1, 100 + i, 50 + i, 2, 1'b1);
      end
      drain("fair");
      check("fair_plots_r0", p_cnt[0], 10);
      check("fair_plots_r1", p_cnt[1], 10);

      // Clipping: two out-of-range beats consumed, one boundary pixel plotted.
      clear_counts();
      push(0, 160, 5, 4, 1'b0);
      push(0, 5, 120, 4, 1'b0);
      push(0, 159, 119, 6, 1'b1);
      drain("clip");
      check("clip_plots", p_cnt[0], 1);
      check("clip_count", int'(clip), 2);
      check("clip_last_x", int'(vx), 159);
      check("clip_last_y", int'(vy), 119);

      // Reset mid-burst after two accepted beats.
      for (int i = 0; i < 5; i++) push(1, 30 + i, 40, 7, i == 4);
      m_beats = 0;
      for (int n = 0; n < 20 && m_beats < 2; n++) step();
      check("midrst_plot_before", int'(plot), 1);
      valid = '0;
      rst = 1'b1;
      #1;
      check("midrst_ready", int'(ready), 0);
      check("midrst_plot", int'(plot), 0);
      check("midrst_busy", int'(busy), 0);
      #1;
      rst = 1'b0;
      model_reset();
      push(0, 1, 1, 1, 1'b1);
      push(1, 2, 2, 2, 1'b1);
      step();
      step();
      check("midrst_rr_grant", int'(grant), 0);
      drain("midrst");

      // Owner goes silent after a non-last beat.
      push(0, 70, 70, 3, 1'b0);
      push(1, 71, 71, 4, 1'b1);
`ifdef ARB_TIMEOUT_EN
      repeat (TMO + 6) step();
      check("tmo_released_grant", int'(grant), 1);
      check("tmo_r1_served", q[1].size(), 0);
`else
      repeat (100) step();
      check("notmo_busy", int'(busy), 1);
      check("notmo_grant", int'(grant), 0);
      check("notmo_r1_blocked", int'(ready), 1);
      push(0, 72, 72, 5, 1'b1);
`endif
      drain("tmo");

      // Random traffic with gaps and out-of-range coordinates.
      gap_pct = 30;
      for (int n = 0; n < 3000; n++) begin
         for (int r = 0; r < NR; r++) begin
            if (q[r].size() == 0 && $urandom_range(0, 3) == 0) begin
               int len;
               len = int'($urandom_range(1, 4));
               for (int b = 0; b < len; b++)
                  push(r, int'($urandom_range(0, 199)), int'($urandom_range(0, 127)),
                       int'($urandom_range(0, 7)), b == len - 1);
            end
         end
         step();
      end
      gap_pct = 0;
      drain("random");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
